// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation stage of the decrypt path.
// Walks the scrambled s_RAM, swapping entries to produce one keystream byte
// per message byte, XORs it with the encrypted ROM and writes the plaintext
// into the decrypted RAM. result_ok reports whether every plaintext byte is
// a lowercase letter or a space.
// All memories have a one-cycle registered read, so every read state holds
// its address for two cycles and captures q in the second one.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic              result_ok,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wren
);

  localparam logic [ADDR_W:0] LAST_K = (ADDR_W+1)'(MSG_LEN);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    CHECK,
    INC_I,
    READ_SI_1,
    READ_SI_2,
    CALC_J,
    READ_SJ_1,
    READ_SJ_2,
    WRITE_SI,
    WRITE_SJ,
    READ_F_1,
    READ_F_2,
    WRITE_D,
    DONE
  } state_t;

  // Plaintext acceptance test: lowercase ASCII letter or space.
  function automatic logic is_text(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7a));
  endfunction

  state_t          state;
  state_t          state_next;
  logic [7:0]      i;
  logic [7:0]      j;
  logic [7:0]      si;
  logic [7:0]      sj;
  logic [7:0]      f;
  logic [ADDR_W:0] k;
  logic [7:0]      f_addr;
  logic [7:0]      dec_byte;

  // Keystream index wraps mod 256 with the byte adder.
  assign f_addr   = si + sj;
  assign dec_byte = f ^ rom_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Algorithm registers: indices, captured s_RAM values, byte counter, verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      i         <= 8'h00;
      j         <= 8'h00;
      si        <= 8'h00;
      sj        <= 8'h00;
      f         <= 8'h00;
      k         <= '0;
      result_ok <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          i         <= 8'h00;
          j         <= 8'h00;
          k         <= '0;
          result_ok <= 1'b1;
        end
        INC_I:     i  <= i + 8'h01;
        READ_SI_2: si <= s_q;
        CALC_J:    j  <= j + si;
        READ_SJ_2: sj <= s_q;
        READ_F_2:  f  <= s_q;
        WRITE_D: begin
          k <= k + 1'b1;
          if (!is_text(dec_byte)) begin
            result_ok <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and memory-port decode; idle ports park on i and k.
  always_comb begin
    state_next  = state;
    finish      = 1'b0;
    s_wren      = 1'b0;
    d_wren      = 1'b0;
    s_address   = i;
    s_data      = 8'h00;
    rom_address = k[ADDR_W-1:0];
    d_address   = k[ADDR_W-1:0];
    d_data      = 8'h00;
    case (state)
      IDLE:      if (start) state_next = INIT;
      INIT:      state_next = CHECK;
      CHECK:     state_next = (k == LAST_K) ? DONE : INC_I;
      INC_I:     state_next = READ_SI_1;
      READ_SI_1: begin
        s_address  = i;
        state_next = READ_SI_2;
      end
      READ_SI_2: begin
        s_address  = i;
        state_next = CALC_J;
      end
      CALC_J:    state_next = READ_SJ_1;
      READ_SJ_1: begin
        s_address  = j;
        state_next = READ_SJ_2;
      end
      READ_SJ_2: begin
        s_address  = j;
        state_next = WRITE_SI;
      end
      WRITE_SI: begin
        s_address  = i;
        s_data     = sj;
        s_wren     = 1'b1;
        state_next = WRITE_SJ;
      end
      WRITE_SJ: begin
        s_address  = j;
        s_data     = si;
        s_wren     = 1'b1;
        state_next = READ_F_1;
      end
      READ_F_1: begin
        s_address   = f_addr;
        rom_address = k[ADDR_W-1:0];
        state_next  = READ_F_2;
      end
      READ_F_2: begin
        s_address   = f_addr;
        rom_address = k[ADDR_W-1:0];
        state_next  = WRITE_D;
      end
      WRITE_D: begin
        d_address  = k[ADDR_W-1:0];
        d_data     = dec_byte;
        d_wren     = 1'b1;
        state_next = CHECK;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

endmodule
